// File: rtl/video_timing_pkg.sv
// rtl/video_timing_pkg.sv - aligner state type, stock panel timings and frame total helper
package video_timing_pkg;

    typedef enum logic {ALIGN = 1'b0, RUN = 1'b1} itc_state_t;

    localparam int MTL2_H_ACTIVE = 800;
    localparam int MTL2_H_FP     = 210;
    localparam int MTL2_H_SYNC   = 30;
    localparam int MTL2_H_BP     = 16;
    localparam int MTL2_V_ACTIVE = 480;
    localparam int MTL2_V_FP     = 22;
    localparam int MTL2_V_SYNC   = 3;
    localparam int MTL2_V_BP     = 20;

    localparam int VGA_H_ACTIVE  = 640;
    localparam int VGA_H_FP      = 16;
    localparam int VGA_H_SYNC    = 96;
    localparam int VGA_H_BP      = 48;
    localparam int VGA_V_ACTIVE  = 480;
    localparam int VGA_V_FP      = 10;
    localparam int VGA_V_SYNC    = 2;
    localparam int VGA_V_BP      = 33;

    function automatic int timing_total(input int active, input int fp, input int sync, input int bp);
        return active + fp + sync + bp;
    endfunction

endpackage

// File: rtl/video_sync_counter.sv
// rtl/video_sync_counter.sv - free-running h/v raster counters with active and sync decode
module video_sync_counter
    import video_timing_pkg::*;
#(
    parameter int H_ACTIVE = MTL2_H_ACTIVE,
    parameter int H_FP     = MTL2_H_FP,
    parameter int H_SYNC   = MTL2_H_SYNC,
    parameter int H_BP     = MTL2_H_BP,
    parameter int V_ACTIVE = MTL2_V_ACTIVE,
    parameter int V_FP     = MTL2_V_FP,
    parameter int V_SYNC   = MTL2_V_SYNC,
    parameter int V_BP     = MTL2_V_BP,
    parameter int CNT_W    = 12
) (
    input  logic             vid_clk,
    input  logic             rst,
    output logic [CNT_W-1:0] h,
    output logic [CNT_W-1:0] v,
    output logic             active,
    output logic             origin,
    output logic             hs_on,
    output logic             vs_on
);

    localparam int H_TOTAL = timing_total(H_ACTIVE, H_FP, H_SYNC, H_BP);
    localparam int V_TOTAL = timing_total(V_ACTIVE, V_FP, V_SYNC, V_BP);

    always_ff @(posedge vid_clk) begin
        if (rst) begin
            h <= '0;
            v <= '0;
        end else if (h == CNT_W'(H_TOTAL - 1)) begin
            h <= '0;
            v <= (v == CNT_W'(V_TOTAL - 1)) ? '0 : v + CNT_W'(1);
        end else begin
            h <= h + CNT_W'(1);
        end
    end

    assign active = (h < CNT_W'(H_ACTIVE)) && (v < CNT_W'(V_ACTIVE));
    assign origin = (h == '0) && (v == '0);
    // vertical sync spans whole lines, so it depends on v alone
    assign hs_on  = (h >= CNT_W'(H_ACTIVE + H_FP)) && (h < CNT_W'(H_ACTIVE + H_FP + H_SYNC));
    assign vs_on  = (v >= CNT_W'(V_ACTIVE + V_FP)) && (v < CNT_W'(V_ACTIVE + V_FP + V_SYNC));

endmodule

// File: rtl/video_itc_gen.sv
// rtl/video_itc_gen.sv - stream-to-raster video output stage; VID_ITC_LCD_SINK_EN adds a second polarity-independent LCD sink
module video_itc_gen
    import video_timing_pkg::*;
#(
    parameter int DATA_W   = 24,
    parameter int H_ACTIVE = MTL2_H_ACTIVE,
    parameter int H_FP     = MTL2_H_FP,
    parameter int H_SYNC   = MTL2_H_SYNC,
    parameter int H_BP     = MTL2_H_BP,
    parameter int V_ACTIVE = MTL2_V_ACTIVE,
    parameter int V_FP     = MTL2_V_FP,
    parameter int V_SYNC   = MTL2_V_SYNC,
    parameter int V_BP     = MTL2_V_BP,
    parameter bit HS_POL   = 1'b0,
    parameter bit VS_POL   = 1'b0,
    parameter int CNT_W    = 12
`ifdef VID_ITC_LCD_SINK_EN
    ,
    parameter bit LCD_HS_POL = 1'b0,
    parameter bit LCD_VS_POL = 1'b0
`endif
) (
    input  logic              vid_clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] s_data,
    input  logic              s_valid,
    input  logic              s_sop,
    output logic              s_ready,
    output logic [DATA_W-1:0] vid_data,
    output logic              vid_de,
    output logic              vid_hs,
    output logic              vid_vs,
    output logic [CNT_W-1:0]  vid_h,
    output logic [CNT_W-1:0]  vid_v,
    output logic              frame_start,
    output logic              underflow,
    output logic              sync_err,
    input  logic              status_clr
`ifdef VID_ITC_LCD_SINK_EN
    ,
    output logic [DATA_W-1:0] lcd_data,
    output logic              lcd_de,
    output logic              lcd_hsd,
    output logic              lcd_vsd
`endif
);

    itc_state_t       state, state_nxt;
    logic [CNT_W-1:0] h, v;
    logic             active, origin, hs_on, vs_on;
    logic             sop_misplaced, show, uf_set, se_set;

    video_sync_counter #(
        .H_ACTIVE(H_ACTIVE), .H_FP(H_FP), .H_SYNC(H_SYNC), .H_BP(H_BP),
        .V_ACTIVE(V_ACTIVE), .V_FP(V_FP), .V_SYNC(V_SYNC), .V_BP(V_BP),
        .CNT_W(CNT_W)
    ) u_counter (
        .vid_clk(vid_clk), .rst(rst), .h(h), .v(v),
        .active(active), .origin(origin), .hs_on(hs_on), .vs_on(vs_on)
    );

    // a frame start anywhere but the origin is left at the head to begin the next frame
    assign sop_misplaced = s_valid && s_sop && !origin;

    always_ff @(posedge vid_clk) begin
        if (rst) state <= ALIGN;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ALIGN: if (s_valid && s_sop && origin) state_nxt = RUN;
            RUN:   if (active && (!s_valid || (s_sop != origin))) state_nxt = ALIGN;
            default: state_nxt = ALIGN;
        endcase
    end

    always_comb begin
        s_ready = 1'b0;
        show    = 1'b0;
        uf_set  = 1'b0;
        se_set  = 1'b0;
        if (!rst) begin
            case (state)
                ALIGN: begin
                    s_ready = !sop_misplaced;
                    show    = s_valid && s_sop && origin;
                end
                RUN: begin
                    s_ready = active && !sop_misplaced;
                    show    = active && s_valid && !sop_misplaced;
                    uf_set  = active && !s_valid;
                    se_set  = active && s_valid && (s_sop != origin);
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge vid_clk) begin
        if (rst) begin
            vid_data    <= '0;
            vid_de      <= 1'b0;
            vid_hs      <= ~HS_POL;
            vid_vs      <= ~VS_POL;
            vid_h       <= '0;
            vid_v       <= '0;
            frame_start <= 1'b0;
            underflow   <= 1'b0;
            sync_err    <= 1'b0;
        end else begin
            vid_data    <= show ? s_data : '0;
            vid_de      <= active;
            vid_hs      <= hs_on ? HS_POL : ~HS_POL;
            vid_vs      <= vs_on ? VS_POL : ~VS_POL;
            vid_h       <= h;
            vid_v       <= v;
            frame_start <= origin;
            underflow   <= uf_set | (underflow & ~status_clr);
            sync_err    <= se_set | (sync_err & ~status_clr);
        end
    end

`ifdef VID_ITC_LCD_SINK_EN
    always_ff @(posedge vid_clk) begin
        if (rst) begin
            lcd_data <= '0;
            lcd_de   <= 1'b0;
            lcd_hsd  <= ~LCD_HS_POL;
            lcd_vsd  <= ~LCD_VS_POL;
        end else begin
            lcd_data <= show ? s_data : '0;
            lcd_de   <= active;
            lcd_hsd  <= hs_on ? LCD_HS_POL : ~LCD_HS_POL;
            lcd_vsd  <= vs_on ? LCD_VS_POL : ~LCD_VS_POL;
        end
    end
`endif

endmodule
